// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Arbiter FSM states, port-owner encoding and default memory bus widths.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LD_GRANT,
    LD_ACK
  } arb_state_t;

  typedef enum logic {
    OWN_PIPE,
    OWN_LOADER
  } mem_owner_t;

  // Only the grant state hands the port to the loader.
  function automatic mem_owner_t owner_of(input arb_state_t s);
    return (s == LD_GRANT) ? OWN_LOADER : OWN_PIPE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Saturating starvation counter for the loader.
// Counts blocked loader cycles; sat tells the arbiter the loader must win next.
module mem_port_arbiter_wait_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = (count == CNT_W'(MAX_WAIT));

  // Priority: reset, then clear on grant, then hold during halt, then count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (inc && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between stage three and the loader.
// Pipeline has priority; a starvation counter forces the loader through after MAX_WAIT blocked cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  arb_state_t next_state;
  mem_owner_t owner;
  logic [3:0] wait_cnt;
  logic       wait_sat;
  logic       grant;
  logic       wait_inc;

  // Loader wins from IDLE when the pipeline is quiet or has starved it long enough.
  assign grant    = (state == IDLE) && ld_req && !halt_sys && (!pipe_req || wait_sat);
  assign wait_inc = (state == IDLE) && ld_req && pipe_req && !grant;

  mem_port_arbiter_wait_counter #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (4)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (wait_inc),
    .clr  (grant),
    .hold (halt_sys),
    .count(wait_cnt),
    .sat  (wait_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = grant ? LD_GRANT : IDLE;
      LD_GRANT: next_state = LD_ACK;
      LD_ACK:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Reset forces pipeline ownership and kills writes even if the state register has not cleared yet.
  always_comb begin
    owner      = rst ? OWN_PIPE : owner_of(state);
    ld_ack     = (state == LD_ACK);
    pipe_stall = 1'b0;
    mem_we     = pipe_we & pipe_req & ~halt_sys & ~rst;
    if (owner == OWN_LOADER) begin
      pipe_stall = pipe_req;
      mem_we     = ld_we;
    end
  end

  assign mem_addr   = (owner == OWN_LOADER) ? ld_addr  : pipe_addr;
  assign mem_wdata  = (owner == OWN_LOADER) ? ld_wdata : pipe_wdata;
  assign pipe_rdata = mem_rdata;

  // Loader read data is captured at the end of the grant cycle and held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rdata <= '0;
    end else if (state == LD_GRANT) begin
      ld_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory model and a loader read-data scoreboard.
// Expected loader read data is queued when a request is driven and popped on each ld_ack.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        halt_sys;
  logic        pipe_req;
  logic        pipe_we;
  logic [15:0] pipe_addr;
  logic [15:0] pipe_wdata;
  logic [15:0] pipe_rdata;
  logic        pipe_stall;
  logic        ld_req;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [15:0] ld_wdata;
  logic        ld_ack;
  logic [15:0] ld_rdata;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        memInit;
  logic [15:0] tbMem [0:255];
  logic [15:0] expQ [$];
  int          checks   = 0;
  int          failures = 0;

  mem_port_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .MAX_WAIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .halt_sys  (halt_sys),
    .pipe_req  (pipe_req),
    .pipe_we   (pipe_we),
    .pipe_addr (pipe_addr),
    .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata),
    .pipe_stall(pipe_stall),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small main-memory model: combinational read, write on the clock edge, preloaded while memInit is high.
  assign mem_rdata = (mem_addr[15:8] == 8'h00) ? tbMem[mem_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) tbMem[i] <= 16'h0000;
      tbMem[8'h20] <= 16'h1234;
      tbMem[8'h50] <= 16'h5A5A;
      tbMem[8'h60] <= 16'h6666;
    end else if (mem_we && mem_addr[15:8] == 8'h00) begin
      tbMem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pReq, input logic pWe, input logic [15:0] pAddr,
                               input logic [15:0] pWdata, input logic lReq, input logic lWe,
                               input logic [15:0] lAddr, input logic [15:0] lWdata, input logic hlt);
    pipe_req   = pReq;
    pipe_we    = pWe;
    pipe_addr  = pAddr;
    pipe_wdata = pWdata;
    ld_req     = lReq;
    ld_we      = lWe;
    ld_addr    = lAddr;
    ld_wdata   = lWdata;
    halt_sys   = hlt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack must match the oldest queued loader expectation.
  always @(negedge clk) begin
    if (ld_ack) begin
      if (expQ.size() == 0) checkOutput("sb_unexpected_ack", 32'(ld_ack), 32'd0);
      else checkOutput("sb_ld_rdata", 32'(ld_rdata), 32'(expQ.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with both requesters active: nothing may be granted or written.
    rst     = 1'b1;
    memInit = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0030, 16'hAAAA, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
      checkOutput("rst_ld_ack", 32'(ld_ack), 32'd0);
      checkOutput("rst_ld_rdata", 32'(ld_rdata), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    end
    step();

    // Loader write with an idle pipeline.
    rst     = 1'b0;
    memInit = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    expQ.push_back(16'h0000);
    @(negedge clk);
    checkOutput("wr_idle_state", 32'(dut.state), 32'(IDLE));
    checkOutput("wr_idle_mem_we", 32'(mem_we), 32'd0);
    step();
    @(negedge clk);
    checkOutput("wr_grant_state", 32'(dut.state), 32'(LD_GRANT));
    checkOutput("wr_grant_mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr_grant_mem_addr", 32'(mem_addr), 32'h0010);
    checkOutput("wr_grant_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    checkOutput("wr_grant_stall", 32'(pipe_stall), 32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("wr_ack", 32'(ld_ack), 32'd1);
    checkOutput("wr_ack_state", 32'(dut.state), 32'(LD_ACK));
    checkOutput("wr_readback", 32'(pipe_rdata), 32'hBEEF);
    step();
    @(negedge clk);
    checkOutput("wr_ack_pulse_end", 32'(ld_ack), 32'd0);
    checkOutput("wr_readback_idle", 32'(pipe_rdata), 32'hBEEF);
    step();

    // Loader read of a preloaded location.
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    expQ.push_back(16'h1234);
    @(negedge clk);
    checkOutput("rd_idle_state", 32'(dut.state), 32'(IDLE));
    step();
    @(negedge clk);
    checkOutput("rd_grant_state", 32'(dut.state), 32'(LD_GRANT));
    checkOutput("rd_grant_stall", 32'(pipe_stall), 32'd0);
    checkOutput("rd_grant_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rd_grant_mem_addr", 32'(mem_addr), 32'h0020);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("rd_ack", 32'(ld_ack), 32'd1);
    checkOutput("rd_ld_rdata", 32'(ld_rdata), 32'h1234);
    step();

    // Starvation: pipeline busy every cycle, loader forced through after the count saturates.
    applyStimulus(1'b1, 1'b1, 16'h0040, 16'h1111, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0);
    expQ.push_back(16'h5A5A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("starve_state_%0d", k), 32'(dut.state), 32'(IDLE));
      checkOutput($sformatf("starve_cnt_%0d", k), 32'(dut.wait_cnt), 32'(k));
      checkOutput($sformatf("starve_stall_%0d", k), 32'(pipe_stall), 32'd0);
      checkOutput($sformatf("starve_mem_we_%0d", k), 32'(mem_we), 32'd1);
      checkOutput($sformatf("starve_mem_addr_%0d", k), 32'(mem_addr), 32'h0040);
      step();
    end
    @(negedge clk);
    checkOutput("starve_grant_state", 32'(dut.state), 32'(LD_GRANT));
    checkOutput("starve_grant_stall", 32'(pipe_stall), 32'd1);
    checkOutput("starve_grant_mem_addr", 32'(mem_addr), 32'h0050);
    checkOutput("starve_grant_mem_we", 32'(mem_we), 32'd0);
    checkOutput("starve_grant_cnt", 32'(dut.wait_cnt), 32'd0);
    step();
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("starve_ack", 32'(ld_ack), 32'd1);
    checkOutput("starve_ack_stall", 32'(pipe_stall), 32'd0);
    checkOutput("starve_pipe_readback", 32'(pipe_rdata), 32'h1111);
    step();

    // Halt: count held, no grant, no pipeline writes; arbitration resumes from the held count.
    applyStimulus(1'b1, 1'b1, 16'h0041, 16'h2222, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0);
    expQ.push_back(16'h6666);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("halt_pre_cnt_%0d", k), 32'(dut.wait_cnt), 32'(k));
      step();
    end
    applyStimulus(1'b1, 1'b1, 16'h0041, 16'h2222, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("halt_state_%0d", k), 32'(dut.state), 32'(IDLE));
      checkOutput($sformatf("halt_cnt_%0d", k), 32'(dut.wait_cnt), 32'd2);
      checkOutput($sformatf("halt_mem_we_%0d", k), 32'(mem_we), 32'd0);
      step();
    end
    applyStimulus(1'b1, 1'b1, 16'h0041, 16'h2222, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("resume_state_%0d", k), 32'(dut.state), 32'(IDLE));
      checkOutput($sformatf("resume_cnt_%0d", k), 32'(dut.wait_cnt), 32'(k));
      checkOutput($sformatf("resume_mem_we_%0d", k), 32'(mem_we), 32'd1);
      step();
    end
    @(negedge clk);
    checkOutput("resume_grant_state", 32'(dut.state), 32'(LD_GRANT));
    checkOutput("resume_grant_stall", 32'(pipe_stall), 32'd1);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("resume_ack", 32'(ld_ack), 32'd1);
    checkOutput("resume_ld_rdata", 32'(ld_rdata), 32'h6666);
    step();

    // Reset during a loader write grant: no write, no ack, counter cleared.
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0070, 16'h7777, 1'b0);
    @(negedge clk);
    checkOutput("rstgrant_idle_state", 32'(dut.state), 32'(IDLE));
    step();
    @(negedge clk);
    checkOutput("rstgrant_state", 32'(dut.state), 32'(LD_GRANT));
    rst      = 1'b1;
    pipe_req = 1'b1;
    #1;
    checkOutput("rstgrant_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rstgrant_stall", 32'(pipe_stall), 32'd0);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("rstgrant_after_state", 32'(dut.state), 32'(IDLE));
    checkOutput("rstgrant_after_ack", 32'(ld_ack), 32'd0);
    checkOutput("rstgrant_after_cnt", 32'(dut.wait_cnt), 32'd0);
    checkOutput("rstgrant_after_rdata", 32'(ld_rdata), 32'd0);
    step();
    @(negedge clk);
    checkOutput("rstgrant_no_late_ack", 32'(ld_ack), 32'd0);
    checkOutput("rstgrant_no_write", 32'(tbMem[8'h70]), 32'd0);
    step();

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
